// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter: wakes the SPI flash from deep power-down (0xAB), then
// serves 32-bit READ (0x03) word fetches for two round-robin requesters.
//   CLK_CPU, resetn          clock, asynchronous active-low reset
//   req0_valid/addr/ready    port 0 (instruction fetch), ready is a 1-cycle pulse
//   req1_valid/addr/ready    port 1 (data load), ready is a 1-cycle pulse
//   rdata                    read word, first received byte in [7:0]
//   flash_ready              high once the wake sequence has completed
//   SPI_CS/SCK/SI, SPI_SO    mode 0 flash pins, MSB first, 2 clocks per bit
module spi_flash_arbiter #(
   parameter int WAKE_WAIT = 4,
   parameter int CS_IDLE   = 2
) (
   input  logic        CLK_CPU,
   input  logic        resetn,
   input  logic        req0_valid,
   input  logic [23:0] req0_addr,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [23:0] req1_addr,
   output logic        req1_ready,
   output logic [31:0] rdata,
   output logic        flash_ready,
   output logic        SPI_CS,
   output logic        SPI_SCK,
   output logic        SPI_SI,
   input  logic        SPI_SO
);
   typedef enum logic [2:0] {S_WAKE_CMD, S_WAKE_WAIT, S_IDLE, S_XFER, S_DONE, S_GAP} state_t;
   localparam logic [7:0] WW = 8'(WAKE_WAIT);
   localparam logic [7:0] CI = 8'(CS_IDLE);
   state_t      state_q;
   logic [5:0]  bit_q;
   logic [7:0]  cnt_q;
   logic [31:0] tx_q, rx_q, rdata_q;
   logic        cs_q, sck_q, si_q, last_q, port_q, fr_q, rdy0_q, rdy1_q;
   logic        gnt_d, gnt1_d;
   logic [23:0] addr_d;
   logic [5:0]  last_bit_d;
   // Round robin: on a tie the port that was not granted last wins.
   always_comb begin
      gnt_d      = req0_valid | req1_valid;
      gnt1_d     = req1_valid & (~req0_valid | ~last_q);
      addr_d     = gnt1_d ? req1_addr : req0_addr;
      last_bit_d = state_q == S_XFER ? 6'd63 : 6'd7;
   end
   always_ff @(posedge CLK_CPU or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_WAKE_CMD;
         bit_q   <= '0;
         cnt_q   <= '0;
         tx_q    <= 32'hAB00_0000;
         rx_q    <= '0;
         rdata_q <= '0;
         cs_q    <= 1'b1;
         sck_q   <= 1'b0;
         si_q    <= 1'b0;
         last_q  <= 1'b1;
         port_q  <= 1'b0;
         fr_q    <= 1'b0;
         rdy0_q  <= 1'b0;
         rdy1_q  <= 1'b0;
      end else begin
         rdy0_q <= 1'b0;
         rdy1_q <= 1'b0;
         case (state_q)
            // Shared bit engine: SI moves on the SCK-low cycle, SO is taken on
            // the edge that raises SCK. The wake command enters with CS still
            // high; reads enter with CS already low from the granting edge.
            S_WAKE_CMD, S_XFER:
               if (cs_q) begin
                  cs_q <= 1'b0;
                  si_q <= tx_q[31];
                  tx_q <= {tx_q[30:0], 1'b0};
               end else if (!sck_q) begin
                  sck_q <= 1'b1;
                  if (bit_q[5]) rx_q <= {rx_q[30:0], SPI_SO};
               end else if (bit_q != last_bit_d) begin
                  sck_q <= 1'b0;
                  bit_q <= bit_q + 6'd1;
                  si_q  <= tx_q[31];
                  tx_q  <= {tx_q[30:0], 1'b0};
               end else begin
                  sck_q <= 1'b0;
                  cs_q  <= 1'b1;
                  si_q  <= 1'b0;
                  bit_q <= '0;
                  cnt_q <= '0;
                  if (state_q == S_XFER) begin
                     rdata_q <= {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
                     rdy0_q  <= ~port_q;
                     rdy1_q  <= port_q;
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_WAKE_WAIT;
                  end
               end
            S_WAKE_WAIT:
               if (cnt_q == WW) begin
                  fr_q    <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            // The granting edge is already bit 0's SCK-low cycle; the READ
            // opcode's MSB is 0, and the rest of {03,addr} is preshifted.
            S_IDLE:
               if (gnt_d) begin
                  cs_q    <= 1'b0;
                  si_q    <= 1'b0;
                  tx_q    <= {7'h03, addr_d, 1'b0};
                  bit_q   <= '0;
                  port_q  <= gnt1_d;
                  last_q  <= gnt1_d;
                  state_q <= S_XFER;
               end
            S_DONE: begin
               cnt_q   <= '0;
               state_q <= S_GAP;
            end
            S_GAP:
               if (cnt_q + 8'd1 >= CI) state_q <= S_IDLE;
               else cnt_q <= cnt_q + 8'd1;
            default: state_q <= S_WAKE_CMD;
         endcase
      end
   end
   assign req0_ready  = rdy0_q;
   assign req1_ready  = rdy1_q;
   assign rdata       = rdata_q;
   assign flash_ready = fr_q;
   assign SPI_CS      = cs_q;
   assign SPI_SCK     = sck_q;
   assign SPI_SI      = si_q;
endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb_spi_flash_arbiter: directed and randomized checks of spi_flash_arbiter against a pin-level flash model.
module tb_spi_flash_arbiter;
   logic        CLK_CPU = 1'b0;
   logic        resetn  = 1'b0;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [23:0] req0_addr, req1_addr;
   logic [31:0] rdata;
   logic        flash_ready, SPI_CS, SPI_SCK, SPI_SI, SPI_SO;
   int          n_cmp = 0, n_fail = 0;
   logic        m_last = 1'b1;
   always #5 CLK_CPU = ~CLK_CPU;
   spi_flash_arbiter dut (
      .CLK_CPU(CLK_CPU), .resetn(resetn),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
      .rdata(rdata), .flash_ready(flash_ready),
      .SPI_CS(SPI_CS), .SPI_SCK(SPI_SCK), .SPI_SI(SPI_SI), .SPI_SO(SPI_SO)
   );
   // Flash array contents: byte at address a.
   function automatic logic [7:0] fbyte(input logic [23:0] a);
      return 8'h11 * (a[7:0] + 8'd1) + a[15:8] + a[23:16] - 8'h05;
   endfunction
   // Reference: four consecutive bytes, first byte in the low lane.
   function automatic logic [31:0] exp_word(input logic [23:0] a);
      return {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)};
   endfunction
   // Per-cycle bus monitor, sampled on the falling clock edge.
   typedef struct {logic port; logic [31:0] data; int low; int hi; int gap;} ev_t;
   ev_t  ev_q[$];
   logic cs_prev = 1'b1, fr_prev = 1'b0, both_seen = 1'b0;
   int   low_run = 0, hi_run = 0, last_low = 0, last_hi = 0, fr_after = -1;
   always @(negedge CLK_CPU) begin
      if (!SPI_CS) begin
         if (cs_prev) last_hi = hi_run;
         low_run++;
         hi_run = 0;
      end else begin
         if (!cs_prev) last_low = low_run;
         low_run = 0;
         hi_run++;
      end
      cs_prev = SPI_CS;
      if (flash_ready && !fr_prev) fr_after = hi_run - 1;
      fr_prev = flash_ready;
      if (req0_ready && req1_ready) both_seen = 1'b1;
      if (req0_ready || req1_ready) ev_q.push_back('{req1_ready, rdata, last_low, hi_run, last_hi});
   end
   // Mode 0 flash: samples SI on SCK rise, presents data bit k before rise k.
   typedef struct {int n; int lowc; logic [63:0] si; logic fr;} fl_t;
   fl_t         fl_q[$];
   int          sck_n = 0;
   logic [63:0] si_sh = '0;
   logic [31:0] stream = '0;
   logic        fr_fall = 1'b0, so_r = 1'b0;
   assign SPI_SO = so_r;
   always @(negedge SPI_CS or posedge SPI_SCK) begin
      if (SPI_SCK) begin
         si_sh = {si_sh[62:0], SPI_SI};
         sck_n++;
         if (sck_n == 32)
            stream = {fbyte(si_sh[23:0]), fbyte(si_sh[23:0] + 24'd1),
                      fbyte(si_sh[23:0] + 24'd2), fbyte(si_sh[23:0] + 24'd3)};
         so_r = (sck_n >= 32 && sck_n < 64) ? stream[5'(63 - sck_n)] : 1'b0;
      end else begin
         sck_n   = 0;
         fr_fall = flash_ready;
      end
   end
   always @(posedge SPI_CS) if (sck_n > 0) fl_q.push_back('{sck_n, low_run, si_sh, fr_fall});
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask
   task automatic get_ev(output ev_t e);
      for (int i = 0; i < 1000 && ev_q.size() == 0; i++) @(negedge CLK_CPU);
      chk("ready_wait", 32'(ev_q.size() > 0), 1);
      if (ev_q.size() > 0) e = ev_q.pop_front();
      else e = '{default: 0};
   endtask
   task automatic get_fl(output fl_t r);
      for (int i = 0; i < 1000 && fl_q.size() == 0; i++) @(negedge CLK_CPU);
      chk("cs_wait", 32'(fl_q.size() > 0), 1);
      if (fl_q.size() > 0) r = fl_q.pop_front();
      else r = '{default: 0};
   endtask
   task automatic wait_cs_low();
      for (int i = 0; i < 1000 && SPI_CS; i++) @(negedge CLK_CPU);
      chk("cs_fall", 32'(SPI_CS), 0);
   endtask
   task automatic check_read(input logic p, input logic [23:0] a, input string t);
      ev_t e;
      fl_t r;
      get_ev(e);
      get_fl(r);
      chk({t, ".port"}, 32'(e.port), 32'(p));
      chk({t, ".rdata"}, e.data, exp_word(a));
      chk({t, ".latency"}, e.low, 128);
      chk({t, ".cs_hi_at_ready"}, e.hi, 1);
      chk({t, ".gap_ge3"}, 32'(e.gap >= 3), 1);
      chk({t, ".bits"}, r.n, 64);
      chk({t, ".cmd"}, r.si[63:32], {8'h03, a});
      chk({t, ".cs_low"}, r.lowc, 128);
      chk({t, ".ready_at_grant"}, 32'(r.fr), 1);
      m_last = p;
   endtask
   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [23:0] a [2];
      logic        v [2];
      logic        p;
      fl_t         r;
      req0_valid = 1'b1;
      req0_addr  = 24'h050000;
      req1_valid = 1'b0;
      req1_addr  = 24'h0;
      repeat (3) @(negedge CLK_CPU);
      chk("rst.pins", {26'd0, SPI_CS, SPI_SCK, SPI_SI, req0_ready, req1_ready, flash_ready}, 32'b100000);
      chk("rst.rdata", rdata, 32'h0);
      resetn = 1'b1;
      get_fl(r);
      chk("wake.bits", r.n, 8);
      chk("wake.cmd", 32'(r.si[7:0]), 32'hAB);
      chk("wake.cs_low", r.lowc, 16);
      check_read(1'b0, 24'h050000, "t2");
      req0_valid = 1'b0;
      chk("t1.fr_delay", fr_after, 5);
      repeat (5) @(negedge CLK_CPU);
      chk("t2.rdata_hold", rdata, 32'h44332211);
      a[0] = 24'($urandom);
      req0_addr  = a[0];
      req0_valid = 1'b1;
      wait_cs_low();
      repeat (5) @(negedge CLK_CPU);
      req0_valid = 1'b0;
      check_read(1'b0, a[0], "t6");
      a[0] = 24'($urandom);
      req0_addr  = a[0];
      req0_valid = 1'b1;
      wait_cs_low();
      repeat (40) @(negedge CLK_CPU);
      a[1] = 24'($urandom);
      req1_addr  = a[1];
      req1_valid = 1'b1;
      check_read(1'b0, a[0], "t4a");
      req0_valid = 1'b0;
      check_read(1'b1, a[1], "t4b");
      req1_valid = 1'b0;
      a[1] = 24'($urandom);
      req1_addr  = a[1];
      req1_valid = 1'b1;
      wait_cs_low();
      repeat (40) @(negedge CLK_CPU);
      #1 resetn = 1'b0;
      #1;
      chk("t5.abort_pins", {29'd0, SPI_CS, SPI_SCK, flash_ready}, 32'b100);
      chk("t5.abort_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      repeat (3) @(negedge CLK_CPU);
      resetn = 1'b1;
      m_last = 1'b1;
      get_fl(r);
      chk("t5.abort_bits", r.n, 20);
      get_fl(r);
      chk("t5.wake_bits", r.n, 8);
      chk("t5.wake_cmd", 32'(r.si[7:0]), 32'hAB);
      chk("t5.no_ready", 32'(ev_q.size()), 0);
      check_read(1'b1, a[1], "t5");
      req1_valid = 1'b0;
      chk("t5.fr_delay", fr_after, 5);
      a[0] = 24'h000100;
      a[1] = 24'h000200;
      v[0] = 1'b1;
      v[1] = 1'b1;
      req0_addr  = a[0];
      req1_addr  = a[1];
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int k = 0; k < 12; k++) begin
         p = (v[0] && v[1]) ? ~m_last : ~v[0];
         check_read(p, a[p], $sformatf("rr%0d", k));
         a[p] = 24'($urandom);
         v[p] = (k < 3) ? 1'b1 : 1'($urandom_range(0, 1));
         if (!v[0] && !v[1]) begin
            v[~p] = 1'b1;
            a[~p] = 24'($urandom);
         end
         req0_addr  = a[0];
         req1_addr  = a[1];
         req0_valid = v[0];
         req1_valid = v[1];
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("never_both_ready", 32'(both_seen), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
